// File: rtl/evu_counter_bank.sv
// evu_counter_bank: multi-channel hardware performance-counter bank.
//
// Each channel selects one pre-decoded event source, samples its per-cycle
// increment into a one-deep pipeline register (stage 1), then accumulates it
// into a wrapping counter (stage 2). The counter keeps a sticky overflow flag
// and a sticky threshold-reached flag. The CSR file programs the channels
// through a single write port and reads the counter values directly.
//
// Optional feature: define EVU_SNAPSHOT_EN to build the snapshot registers.
// Without it, snap_o is tied to 0 and snap_i is ignored.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   evt_inc_i      per-event increment, slice e is event e (slice 0 unused)
//   inhibit_i      global count inhibit, gates sampling only
//   wr_valid_i     configuration write strobe (always accepted)
//   wr_idx_i       target channel of the write
//   wr_type_i      0 CTRL, 1 COUNT, 2 THRESH, 3 CLEAR_FLAGS
//   wr_data_i      write data; CTRL uses bit 0 = enable, upper bits = select
//   count_o        packed counter values, channel c at [c*CntWidth +: CntWidth]
//   ovf_o          sticky overflow flags
//   irq_o          sticky threshold-reached flags
//   snap_o         packed snapshot values
//   snap_i         snapshot request

module evu_counter_bank #(
    parameter int unsigned NrCounters = 4,
    parameter int unsigned NrEvents   = 16,
    parameter int unsigned CntWidth   = 48,
    parameter int unsigned IncWidth   = 2,
    localparam int unsigned IdxWidth  = (NrCounters > 1) ? $clog2(NrCounters) : 1,
    localparam int unsigned SelWidth  = $clog2(NrEvents)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NrEvents*IncWidth-1:0]   evt_inc_i,
    input  logic                           inhibit_i,
    input  logic                           wr_valid_i,
    input  logic [IdxWidth-1:0]            wr_idx_i,
    input  logic [1:0]                     wr_type_i,
    input  logic [CntWidth-1:0]            wr_data_i,
    output logic [NrCounters*CntWidth-1:0] count_o,
    output logic [NrCounters-1:0]          ovf_o,
    output logic [NrCounters-1:0]          irq_o,
    output logic [NrCounters*CntWidth-1:0] snap_o,
    input  logic                           snap_i
);

    typedef enum logic [1:0] {
        WrCtrl   = 2'd0,
        WrCount  = 2'd1,
        WrThresh = 2'd2,
        WrClear  = 2'd3
    } wr_type_e;

    wr_type_e wr_type;
    assign wr_type = wr_type_e'(wr_type_i);

    logic                en_q     [NrCounters];
    logic                en_d     [NrCounters];
    logic [SelWidth-1:0] sel_q    [NrCounters];
    logic [SelWidth-1:0] sel_d    [NrCounters];
    logic [IncWidth-1:0] inc_q    [NrCounters];
    logic [IncWidth-1:0] inc_d    [NrCounters];
    logic [CntWidth-1:0] count_q  [NrCounters];
    logic [CntWidth-1:0] count_d  [NrCounters];
    logic [CntWidth-1:0] thresh_q [NrCounters];
    logic [CntWidth-1:0] thresh_d [NrCounters];
    logic                ovf_q    [NrCounters];
    logic                ovf_d    [NrCounters];
    logic                irq_q    [NrCounters];
    logic                irq_d    [NrCounters];

    always_comb begin
        for (int c = 0; c < NrCounters; c++) begin
            logic                wr_hit;
            logic [CntWidth:0]   sum;
            logic                set_ovf;
            logic                set_irq;
            logic [IncWidth-1:0] sampled;
            int                  sel_idx;

            wr_hit  = wr_valid_i && (wr_idx_i == IdxWidth'(c));
            sel_idx = int'(sel_q[c]);

            // Stage 1: pick the selected event; index 0 and out-of-range selects count nothing.
            sampled = '0;
            if (en_q[c] && (sel_idx != 0) && !inhibit_i && (sel_idx < int'(NrEvents))) begin
                sampled = evt_inc_i[sel_idx*IncWidth +: IncWidth];
            end

            // Stage 2: the extra sum bit is the carry out that marks a wrap.
            sum     = {1'b0, count_q[c]} + {{(CntWidth + 1 - IncWidth){1'b0}}, inc_q[c]};
            set_ovf = sum[CntWidth];
            // Only a below-to-at-or-above transition fires, including after a wrap.
            set_irq = (thresh_q[c] != '0) && (count_q[c] < thresh_q[c])
                      && (sum[CntWidth-1:0] >= thresh_q[c]);

            en_d[c]     = en_q[c];
            sel_d[c]    = sel_q[c];
            inc_d[c]    = sampled;
            count_d[c]  = sum[CntWidth-1:0];
            thresh_d[c] = thresh_q[c];
            ovf_d[c]    = ovf_q[c];
            irq_d[c]    = irq_q[c];

            if (wr_hit) begin
                unique case (wr_type)
                    WrCtrl: begin
                        en_d[c]  = wr_data_i[0];
                        sel_d[c] = wr_data_i[SelWidth:1];
                        // Flush so nothing sampled under the old selection lands later.
                        inc_d[c] = '0;
                    end
                    WrCount: begin
                        // A loaded value replaces the in-flight increment and never flags.
                        count_d[c] = wr_data_i;
                        set_ovf    = 1'b0;
                        set_irq    = 1'b0;
                    end
                    WrThresh: begin
                        thresh_d[c] = wr_data_i;
                    end
                    WrClear: begin
                        if (wr_data_i[0]) ovf_d[c] = 1'b0;
                        if (wr_data_i[1]) irq_d[c] = 1'b0;
                    end
                    default: ;
                endcase
            end

            // Set after clear so a simultaneous set event wins.
            if (set_ovf) ovf_d[c] = 1'b1;
            if (set_irq) irq_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NrCounters; c++) begin
                en_q[c]     <= 1'b0;
                sel_q[c]    <= '0;
                inc_q[c]    <= '0;
                count_q[c]  <= '0;
                thresh_q[c] <= '0;
                ovf_q[c]    <= 1'b0;
                irq_q[c]    <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NrCounters; c++) begin
                en_q[c]     <= en_d[c];
                sel_q[c]    <= sel_d[c];
                inc_q[c]    <= inc_d[c];
                count_q[c]  <= count_d[c];
                thresh_q[c] <= thresh_d[c];
                ovf_q[c]    <= ovf_d[c];
                irq_q[c]    <= irq_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NrCounters; c++) begin
            count_o[c*CntWidth +: CntWidth] = count_q[c];
            ovf_o[c]                        = ovf_q[c];
            irq_o[c]                        = irq_q[c];
        end
    end

`ifdef EVU_SNAPSHOT_EN
    logic [CntWidth-1:0] snap_q [NrCounters];

    // Captures count_d so the snapshot matches what count_o shows next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NrCounters; c++) begin
                snap_q[c] <= '0;
            end
        end else if (snap_i) begin
            for (int c = 0; c < NrCounters; c++) begin
                snap_q[c] <= count_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NrCounters; c++) begin
            snap_o[c*CntWidth +: CntWidth] = snap_q[c];
        end
    end
`else
    logic unused_snap;
    assign unused_snap = snap_i;
    assign snap_o      = '0;
`endif

endmodule

// File: doc/evu_counter_bank.md
# evu_counter_bank

Parametrised multi-channel hardware performance-counter bank, the successor to the single-output 4-bit event select mux. It receives pre-decoded per-cycle event increments from the commit, cache, MMU, issue and frontend stages. Each of `NrCounters` channels independently selects one event, accumulates a multi-count increment per cycle (e.g. two loads committed together), detects wrap-around and raises a threshold interrupt. It sits beside the CSR file, which owns the configuration write port and reads the counter values.

## Interface
- `NrCounters`, 4: number of independent counter channels (1..16).
- `NrEvents`, 16: number of event sources; event index 0 is reserved as "no event".
- `CntWidth`, 48: counter, threshold and write-data width (8..64).
- `IncWidth`, 2: width of each per-cycle event increment; maximum increment is 2^IncWidth-1.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset. Asynchronous, active-low.
- `evt_inc_i` input NrEvents*IncWidth: per-event increment for this cycle. Slice e is event e. Slice 0 is ignored.
- `inhibit_i` input 1: global count inhibit, e.g. debug mode.
- `wr_valid_i` input 1: configuration write strobe. Always accepted; there is no ready signal.
- `wr_idx_i` input $clog2(NrCounters): target channel.
- `wr_type_i` input 2: write type. 0 = CTRL, 1 = COUNT, 2 = THRESH, 3 = CLEAR_FLAGS.
- `wr_data_i` input CntWidth: write data. For CTRL: bit 0 is enable, bits [$clog2(NrEvents):1] are the event select.
- `count_o` output NrCounters*CntWidth: current counter values.
- `ovf_o` output NrCounters: sticky overflow flags.
- `irq_o` output NrCounters: sticky threshold-reached flags.
- `snap_o` output NrCounters*CntWidth: snapshot registers (see Configuration).
- `snap_i` input 1: snapshot request.

## Operation
- Each channel holds these registers: `en`, `sel`, `count`, `thresh`, `ovf`, `irq`.
- Stage 1 (sample): `inc_q[c]` is registered as follows.
  - `evt_inc_i[sel[c]]` when `en[c]` is set, `sel[c]` is nonzero and `inhibit_i` is 0.
  - Otherwise 0.
  - An out-of-range `sel` (≥ NrEvents) selects 0.
- Stage 2 (accumulate): `count[c] <= count[c] + inc_q[c]`.
  - The addition is modulo 2^CntWidth, with `inc_q` zero-extended.
  - A carry out of the MSB sets `ovf[c]`; the count wraps to the low bits.
- Threshold: `irq[c]` is set in the cycle that `count` transitions from below `thresh` to at-or-above `thresh`.
  - This includes a jump past `thresh` by an increment greater than 1.
  - It includes wrap-around landing at or above `thresh`.
  - A `thresh` of 0 disables the threshold; `irq` never sets.
- CTRL write:
  - Updates `en` and `sel`.
  - Flushes `inc_q[c]` to 0 in the same edge, so no event from the old selection lands after reprogramming.
- COUNT write:
  - Loads `count[c]`.
  - Discards that cycle's stage-2 increment.
  - Does not set `ovf` or `irq`, even if the value written is ≥ `thresh`.
- THRESH write:
  - Loads `thresh[c]`.
  - Does not re-evaluate `irq`.
- CLEAR_FLAGS write:
  - `wr_data_i[0]` clears `ovf`.
  - `wr_data_i[1]` clears `irq`.
  - When an overflow or threshold-crossing set event occurs in the same cycle, the set wins.
- Channels other than `wr_idx_i` are unaffected by a write.

## Timing
- Reset values: `count`, `thresh`, `inc_q`, `en`, `sel`, `ovf`, `irq` are all 0. Therefore `count_o`, `ovf_o`, `irq_o` and `snap_o` are 0.
- Event latency:
  - An increment presented at cycle N is registered in `inc_q` at the end of N.
  - It is added to `count` at the end of N+1.
  - It is visible on `count_o` in N+2.
- `ovf_o` and `irq_o` are registered outputs. They update on the same edge as the `count` change that causes them.
- Write latency: a write in cycle N is visible on the outputs in N+1.
- `inhibit_i` gates stage 1 only. Increments already in `inc_q` still land one cycle later.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Increments in flight are lost.

## Configuration
- Macro: `EVU_SNAPSHOT_EN`.
- Defined:
  - `snap_i` high copies the post-update value of every `count` (the value `count_o` shows next cycle) into `snap_o` atomically on the same edge.
  - `snap_o` holds until the next `snap_i`.
  - A simultaneous COUNT write is reflected in the snapshot.
- Undefined:
  - No snapshot registers are built.
  - `snap_o` is tied to 0.
  - `snap_i` is ignored.
  - Ports remain present.

## Test plan
- Reset, then CTRL write ch0 with en=1, sel=3; drive event 3 with inc=2 for 5 cycles → `count_o[0]` equals 10, reached exactly 2 cycles after the last event; ch1–3 remain 0.
- COUNT write ch1 = 2^48−2, sel=5, en=1; drive event 5 inc=3 once → `count_o[1]`=1, `ovf_o[1]`=1, and `irq_o[1]` stays 0 while `thresh`=0.
- THRESH ch2 = 100, COUNT ch2 = 98; drive inc=3 on the selected event → count=101 and `irq_o[2]`=1 on the same edge. CLEAR_FLAGS with data=2 → `irq_o[2]`=0 next cycle.
- Ch0 counting inc=1 every cycle; COUNT write of 50 in cycle N → `count_o[0]`=50 in N+1 and 51 in N+2. Re-CTRL to sel=0 → count freezes after at most 1 further increment.
- `inhibit_i`=1 for 4 cycles while event active at inc=1 → count advances by exactly 1 (the in-flight `inc_q`) and then holds. Also: CLEAR_FLAGS coinciding with an overflow edge → `ovf` remains 1.
- With `EVU_SNAPSHOT_EN`: ch0=20 counting inc=1 per cycle; pulse `snap_i` → `snap_o[0]`=21 (the post-update value) and stays 21 while `count_o[0]` keeps advancing. Without the macro, `snap_o` stays 0.
